// File: rtl/lfsr10_bist_ctrl.sv
// lfsr10_bist_ctrl: BIST sequencer. Streams a seeded, counted run of
// x^10 + x^7 + 1 LFSR bits to a device under test, compacts the serial
// response into a 10-bit MISR and compares the final signature with a
// golden value.
module lfsr10_bist_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [9:0] seed,
  input  logic [9:0] pat_count,
  input  logic [9:0] golden,
  input  logic       resp_in,
  output logic       pattern_out,
  output logic       pattern_valid,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [9:0] lfsr;
  logic [9:0] misr;
  logic [9:0] count;
  logic       pass_q;

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; abort beats start, start only counts in IDLE/DONE.
  // NOTE: the default assignment up front keeps this block free of latches
  // on paths that do not assign state_nxt explicitly.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_SEED;
      S_SEED: begin
        if (abort)             state_nxt = S_IDLE;
        else if (count == '0)  state_nxt = S_CHECK;
        else                   state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort)              state_nxt = S_IDLE;
        else if (count == 10'd1) state_nxt = S_CHECK;
      end
      S_CHECK: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: count latch, LFSR seed/shift, MISR compaction, compare result.
  // An abort in SEED or RUN freezes LFSR and MISR so the partial signature
  // stays visible.
  // NOTE: every datapath flop is a plain register, so all of them get an
  // explicit reset value; there is no memory array here to leave unreset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr   <= 10'h001;
      misr   <= '0;
      count  <= '0;
      pass_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            count  <= pat_count;
            pass_q <= 1'b0;
          end
        end
        S_SEED: begin
          if (!abort) begin
            // All-zero is the lock-up state of an XOR LFSR.
            lfsr <= (seed == '0) ? 10'h001 : seed;
            misr <= '0;
          end
        end
        S_RUN: begin
          if (!abort) begin
            lfsr  <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            misr  <= {misr[8:0], misr[9] ^ misr[6] ^ resp_in};
            count <= count - 10'd1;
          end
        end
        S_CHECK: pass_q <= (misr == golden);
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only; no input-to-output path.
  always_comb begin
    pattern_valid = (state == S_RUN);
    pattern_out   = (state == S_RUN) & lfsr[9];
    busy          = (state == S_SEED) | (state == S_RUN) | (state == S_CHECK);
    done          = (state == S_DONE);
    pass          = pass_q;
    signature     = misr;
  end

endmodule
